// File: rtl/irq_pkg.sv
// Shared definitions for the MIPS interrupt controller.
//   NSRC          : number of interrupt sources
//   IRQ_*         : cfg_idx register indices
//   irq_state_e   : controller FSM states
//   STAT_*        : bit positions inside stat_o
package irq_pkg;

    localparam int unsigned NSRC = 4;

    localparam logic [2:0] IRQ_VEC0  = 3'd0;
    localparam logic [2:0] IRQ_VEC1  = 3'd1;
    localparam logic [2:0] IRQ_VEC2  = 3'd2;
    localparam logic [2:0] IRQ_VEC3  = 3'd3;
    localparam logic [2:0] IRQ_EN    = 3'd4;
    localparam logic [2:0] IRQ_PEND  = 3'd5;
    localparam logic [2:0] IRQ_FORCE = 3'd6;
    localparam logic [2:0] IRQ_EOI   = 3'd7;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StReq     = 2'd1,
        StService = 2'd2
    } irq_state_e;

    localparam int unsigned STAT_PEND_LSB  = 0;
    localparam int unsigned STAT_EN_LSB    = 4;
    localparam int unsigned STAT_GRANT_LSB = 8;
    localparam int unsigned STAT_REQ       = 10;
    localparam int unsigned STAT_SVC       = 11;
    localparam int unsigned STAT_GEN       = 31;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
//   req : request vector
//   any : at least one request set
//   idx : index of the winning request (0 when none)
module irq_prio_enc
    import irq_pkg::*;
(
    input  logic [NSRC-1:0] req,
    output logic            any,
    output logic [1:0]      idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Scan downward so the lowest set bit is the last to assign.
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 2'(i);
            end
        end
    end

endmodule

// File: rtl/mips_irq_ctl.sv
// Interrupt controller: latches source edges into pending bits, masks, arbitrates by
// fixed priority and presents a vector with a req/ack handshake, holding the in-service
// state until an EOI write.
//   clk, rst          : clock, synchronous active-low reset
//   src_i             : synchronized source levels (timer, key1, key2, uart rx)
//   cfg_we/idx/din    : register write port
//   irq_ack_i         : CPU acknowledge pulse
//   irq_req_o         : registered interrupt request
//   irq_addr_o        : registered vector address, valid while irq_req_o
//   stat_o            : status word
module mips_irq_ctl
    import irq_pkg::*;
#(
    parameter logic [31:0] VEC_RST = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_i,
    input  logic            cfg_we,
    input  logic [2:0]      cfg_idx,
    input  logic [31:0]     cfg_din,
    input  logic            irq_ack_i,
    output logic            irq_req_o,
    output logic [31:0]     irq_addr_o,
    output logic [31:0]     stat_o
);

    logic [31:0]     vec_q [NSRC];
    logic [NSRC-1:0] en_q;
    logic            gen_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] src_d;
    logic            first_q;
    logic [1:0]      grant_q, grant_d;
    irq_state_e      state_q, state_d;
    logic            req_d;
    logic [31:0]     addr_d;

    logic [NSRC-1:0] rise, frc, w1c, ack_clr, elig;
    logic            elig_any;
    logic [1:0]      win;
    logic            vec_wr, en_wr, eoi_wr;

    assign vec_wr = cfg_we && !cfg_idx[2];
    assign en_wr  = cfg_we && (cfg_idx == IRQ_EN);
    assign eoi_wr = cfg_we && (cfg_idx == IRQ_EOI);
    assign frc    = (cfg_we && (cfg_idx == IRQ_FORCE)) ? cfg_din[NSRC-1:0] : '0;
    assign w1c    = (cfg_we && (cfg_idx == IRQ_PEND))  ? cfg_din[NSRC-1:0] : '0;

    // src_d is cleared by reset; the first cycle after reset only reloads it, so a
    // source already high at release is not mistaken for a rising edge.
    assign rise = src_i & ~src_d & {NSRC{~first_q}};

    assign elig = pend_q & en_q & {NSRC{gen_q}};

    irq_prio_enc u_prio_enc (
        .req (elig),
        .any (elig_any),
        .idx (win)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        req_d   = irq_req_o;
        addr_d  = irq_addr_o;
        ack_clr = '0;
        case (state_q)
            StIdle: begin
                if (elig_any) begin
                    state_d = StReq;
                    grant_d = win;
                    req_d   = 1'b1;
                    addr_d  = vec_q[win];
                end
            end
            StReq: begin
                if (irq_ack_i) begin
                    state_d          = StService;
                    ack_clr[grant_q] = 1'b1;
                    req_d            = 1'b0;
                    addr_d           = '0;
                end else if (!elig[grant_q]) begin
                    // Granted source withdrawn: retract without re-arbitrating here.
                    state_d = StIdle;
                    req_d   = 1'b0;
                    addr_d  = '0;
                end
            end
            StService: begin
                if (eoi_wr) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
                addr_d  = '0;
            end
        endcase
    end

    // Sets (edge/force) override clears (W1C/ack) in the same cycle.
    assign pend_d = (pend_q & ~(w1c | ack_clr)) | rise | frc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NSRC; i++) begin
                vec_q[i] <= VEC_RST;
            end
            en_q       <= '0;
            gen_q      <= 1'b0;
            pend_q     <= '0;
            src_d      <= '0;
            first_q    <= 1'b1;
            grant_q    <= '0;
            state_q    <= StIdle;
            irq_req_o  <= 1'b0;
            irq_addr_o <= '0;
        end else begin
            if (vec_wr) begin
                vec_q[cfg_idx[1:0]] <= cfg_din;
            end
            if (en_wr) begin
                en_q  <= cfg_din[NSRC-1:0];
                gen_q <= cfg_din[31];
            end
            pend_q     <= pend_d;
            src_d      <= src_i;
            first_q    <= 1'b0;
            grant_q    <= grant_d;
            state_q    <= state_d;
            irq_req_o  <= req_d;
            irq_addr_o <= addr_d;
        end
    end

    always_comb begin
        stat_o                              = '0;
        stat_o[STAT_PEND_LSB +: NSRC]       = pend_q;
        stat_o[STAT_EN_LSB +: NSRC]         = en_q;
        stat_o[STAT_GRANT_LSB +: 2]         = grant_q;
        stat_o[STAT_REQ]                    = (state_q == StReq);
        stat_o[STAT_SVC]                    = (state_q == StService);
        stat_o[STAT_GEN]                    = gen_q;
    end

endmodule
